sonar_array: RTL and testbench

- Parametrised successor to the three-channel front sonar controller. It drives N_CH ultrasonic rangers from one time-multiplexed engine.
- Channels fire strictly round-robin, one at a time, with a settle gap between them to prevent crosstalk.
- For each channel it measures echo pulse width in clk cycles and publishes a per-channel range with a valid strobe and a timeout flag.
- Sits between the sonar connector pins and the odometry/obstacle logic.

---
 rtl/sonar_pkg.sv | 27 ++
 rtl/sonar_median3.sv | 37 +++
 rtl/sonar_array.sv | 196 +++++++++++++++++++
 tb/tb_sonar_array.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared types and sizing helpers for the multi-channel sonar scanner.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GAP
  } sonar_state_t;

  // Channel-index width: $clog2 of the channel count, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold every value 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  // All-ones value of a w-bit result; used for saturation and timeouts.
  function automatic logic [63:0] sat_value(input int unsigned w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/sonar_median3.sv
// Per-channel median-of-three filter: the two previous raw results plus the
// incoming one form the window; the median is registered on each update.
module sonar_median3 #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] med
);

  logic [W-1:0] h0_q, h1_q;
  logic [W-1:0] lo, hi, mid, med_d;

  // median(a,b,c) = max(min(a,b), min(max(a,b), c))
  always_comb begin
    lo    = (in_data < h0_q) ? in_data : h0_q;
    hi    = (in_data < h0_q) ? h0_q : in_data;
    mid   = (hi < h1_q) ? hi : h1_q;
    med_d = (mid > lo) ? mid : lo;
  end

  // Shift the window and latch the new median on each raw result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h0_q <= '0;
      h1_q <= '0;
      med  <= '0;
    end else if (in_valid) begin
      h1_q <= h0_q;
      h0_q <= in_data;
      med  <= med_d;
    end
  end

endmodule

// File: rtl/sonar_array.sv
// Round-robin N-channel ultrasonic ranger engine. One channel at a time is
// triggered, its echo width is measured in clk cycles, and a per-channel range
// is published with valid/timeout strobes, followed by a settle gap.
// Optional build macro SONAR_MEDIAN_EN: publish the median of the last three
// raw results per channel, one cycle later than the raw result.
module sonar_array
  import sonar_pkg::*;
#(
  parameter int unsigned N_CH           = 3,
  parameter int unsigned CNT_W          = 20,
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned GAP_CYCLES     = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [N_CH-1:0]       echo,
  output logic [N_CH-1:0]       trig,
  output logic [N_CH*CNT_W-1:0] range,
  output logic [N_CH-1:0]       range_valid,
  output logic [N_CH-1:0]       timeout,
  output logic                  busy
);

  localparam int unsigned CH_W  = idx_width(N_CH);
  localparam int unsigned TW_T  = cnt_width(TRIG_CYCLES);
  localparam int unsigned TW_G  = cnt_width(GAP_CYCLES);
  localparam int unsigned PH_W  = (TW_T > TW_G) ? TW_T : TW_G;
  localparam int unsigned TMO_W = cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned PAD_N = 1 << CH_W;

  localparam logic [CNT_W-1:0] SAT       = CNT_W'(sat_value(CNT_W));
  localparam logic [PH_W-1:0]  TRIG_LAST = PH_W'(TRIG_CYCLES - 1);
  localparam logic [PH_W-1:0]  GAP_LAST  = PH_W'(GAP_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);

  sonar_state_t      state_q;
  logic [CH_W-1:0]   ch_q, ch_nxt;
  logic [PH_W-1:0]   phase_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [CNT_W-1:0]  width_q;
  logic [N_CH-1:0]   sync1_q, sync2_q;
  logic [PAD_N-1:0]  sync_pad;
  logic              echo_act, echo_prev_q, tmo_hit;
  logic [N_CH-1:0]   trig_q, pub_valid_q, pub_tout_q;
  logic [CNT_W-1:0]  res_q   [N_CH];
  logic [CNT_W-1:0]  out_arr [N_CH];

  // Two-flop synchroniser on every echo pin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= echo;
      sync2_q <= sync1_q;
    end
  end

  // Pad to a power of two so the channel index never selects past the vector.
  assign sync_pad = PAD_N'(sync2_q);
  assign echo_act = sync_pad[ch_q];
  assign tmo_hit  = (tmo_q == TMO_LAST);

  // Next channel in round-robin order.
  always_comb begin
    ch_nxt = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
  end

  // Scan FSM: trigger, wait for a fresh rise, measure, publish, settle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      phase_q     <= '0;
      tmo_q       <= '0;
      width_q     <= '0;
      echo_prev_q <= 1'b0;
      trig_q      <= '0;
      pub_valid_q <= '0;
      pub_tout_q  <= '0;
      for (int i = 0; i < N_CH; i++) res_q[i] <= '0;
    end else begin
      pub_valid_q <= '0;
      pub_tout_q  <= '0;
      // Previous sample of the active channel; ch is stable from TRIG onward.
      echo_prev_q <= echo_act;
      unique case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= TRIG;
            trig_q  <= N_CH'(1) << ch_q;
            phase_q <= '0;
          end
        end
        TRIG: begin
          if (phase_q == TRIG_LAST) begin
            trig_q  <= '0;
            tmo_q   <= '0;
            state_q <= WAIT_RISE;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        WAIT_RISE, MEASURE: begin
          // Timeout is checked first so it wins over a same-cycle echo fall.
          if (tmo_hit) begin
            for (int i = 0; i < N_CH; i++) if (ch_q == CH_W'(i)) res_q[i] <= SAT;
            pub_valid_q <= N_CH'(1) << ch_q;
            pub_tout_q  <= N_CH'(1) << ch_q;
            phase_q     <= '0;
            state_q     <= GAP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (state_q == WAIT_RISE) begin
              // Requiring a low sample first rejects an echo still high from before.
              if (echo_act && !echo_prev_q) begin
                width_q <= CNT_W'(1);
                state_q <= MEASURE;
              end
            end else if (echo_act) begin
              width_q <= (width_q == SAT) ? width_q : width_q + 1'b1;
            end else begin
              for (int i = 0; i < N_CH; i++) if (ch_q == CH_W'(i)) res_q[i] <= width_q;
              pub_valid_q <= N_CH'(1) << ch_q;
              phase_q     <= '0;
              state_q     <= GAP;
            end
          end
        end
        GAP: begin
          if (phase_q == GAP_LAST) begin
            ch_q    <= ch_nxt;
            phase_q <= '0;
            if (enable) begin
              trig_q  <= N_CH'(1) << ch_nxt;
              state_q <= TRIG;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign trig = trig_q;
  assign busy = (state_q != IDLE);

`ifdef SONAR_MEDIAN_EN
  logic [N_CH-1:0] valid_dly_q, tout_dly_q;

  // Strobes follow the registered median by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_dly_q <= '0;
      tout_dly_q  <= '0;
    end else begin
      valid_dly_q <= pub_valid_q;
      tout_dly_q  <= pub_tout_q;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_med
    sonar_median3 #(
      .W(CNT_W)
    ) u_med (
      .clk     (clk),
      .reset   (reset),
      .in_valid(pub_valid_q[i]),
      .in_data (res_q[i]),
      .med     (out_arr[i])
    );
  end

  assign range_valid = valid_dly_q;
  assign timeout     = tout_dly_q;
`else
  for (genvar i = 0; i < N_CH; i++) begin : g_raw
    assign out_arr[i] = res_q[i];
  end

  assign range_valid = pub_valid_q;
  assign timeout     = pub_tout_q;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_pack
    assign range[i*CNT_W +: CNT_W] = out_arr[i];
  end

endmodule

// File: tb/tb_sonar_array.sv
// Scoreboard bench for sonar_array: stimulus pushes expected results, a
// negedge monitor pops and compares each published strobe.
module tb_sonar_array;

  localparam int NCH  = 3;
  localparam int CW   = 20;
  localparam int TRG  = 4;
  localparam int GAPC = 8;
  localparam int TMO  = 100;
`ifdef SONAR_MEDIAN_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam logic [CW-1:0] ALL1 = 20'hFFFFF;

  typedef struct {
    int            ch;
    logic [CW-1:0] val;
    logic          tmo;
    int            due;
  } exp_t;

  logic              clk, reset, enable, busy;
  logic [NCH-1:0]    echo, trig, rv, tmo;
  logic [NCH*CW-1:0] rng;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors, errors, cyc, rise_cyc, last_valid_cyc, f;

  sonar_array #(
    .N_CH          (NCH),
    .CNT_W         (CW),
    .TRIG_CYCLES   (TRG),
    .TIMEOUT_CYCLES(TMO),
    .GAP_CYCLES    (GAPC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .echo       (echo),
    .trig       (trig),
    .range      (rng),
    .range_valid(rv),
    .timeout    (tmo),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (!$onehot0(trig)) begin
        errors++;
        $display("FAIL trig_overlap: got 0x%0h, expected at most one bit", trig);
      end
      if ((tmo & ~rv) != '0) begin
        errors++;
        $display("FAIL tmo_alone: got timeout 0x%0h with valid 0x%0h", tmo, rv);
      end
      if (rv != '0) begin
        last_valid_cyc = cyc;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got valid 0x%0h, expected none", rv);
        end else begin
          mon_e = sb.pop_front();
          chk($sformatf("valid_ch%0d", mon_e.ch), 64'(rv), 64'(1 << mon_e.ch));
          chk($sformatf("range_ch%0d", mon_e.ch), 64'(rng[mon_e.ch*CW +: CW]), 64'(mon_e.val));
          chk($sformatf("timeout_ch%0d", mon_e.ch), 64'(tmo), mon_e.tmo ? 64'(1 << mon_e.ch) : 64'd0);
          chk($sformatf("latency_ch%0d", mon_e.ch), 64'(cyc), 64'(mon_e.due));
        end
      end
    end
  end

  // Wait for channel ch to trigger, check it is the channel firing and the pulse length.
  task automatic wait_trig(input int ch, output int fall_cyc);
    int n;
    n = 0;
    while (trig == '0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (trig == '0) begin
      errors++;
      $display("FAIL trig_wait_ch%0d: got no trigger, expected trig[%0d]", ch, ch);
      fall_cyc = cyc;
      return;
    end
    chk($sformatf("trig_sel_ch%0d", ch), 64'(trig), 64'(1 << ch));
    rise_cyc = cyc;
    n = 0;
    while (trig != '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("trig_len_ch%0d", ch), 64'(n), 64'(TRG));
    fall_cyc = cyc;
  endtask

  // Raw echo pulse of w cycles starting dly cycles from now.
  task automatic pulse(input int ch, input int dly, input int w, input logic [CW-1:0] expv);
    exp_t e;
    repeat (dly) @(posedge clk);
    #1 echo[ch] = 1'b1;
    repeat (w) @(posedge clk);
    #1 echo[ch] = 1'b0;
    e = '{ch: ch, val: expv, tmo: 1'b0, due: cyc + LAT};
    sb.push_back(e);
  endtask

  // Channel left silent: expect a timeout TMO cycles after its trigger ends.
  task automatic silent(input int ch, input logic [CW-1:0] expv);
    exp_t e;
    int   fc;
    wait_trig(ch, fc);
    e = '{ch: ch, val: expv, tmo: 1'b1, due: fc + TMO + (LAT - 3)};
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    vectors = 0; errors = 0; cyc = 0; last_valid_cyc = 0; rise_cyc = 0;
    reset = 1'b0; enable = 1'b0; echo = '0;
    #12;
    chk("reset_trig", 64'(trig), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    #3 reset = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_trig", 64'(trig), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_range", 64'(rng), 64'd0);
    chk("idle_valid", 64'(rv), 64'd0);

    @(posedge clk);
    #1 enable = 1'b1;
`ifdef SONAR_MEDIAN_EN
    wait_trig(0, f);
    pulse(0, 5, 10, 20'd0);
    silent(1, 20'd0);
    silent(2, 20'd0);
    wait_trig(0, f);
    pulse(0, 5, 50, 20'd10);
    silent(1, ALL1);
    silent(2, ALL1);
    wait_trig(0, f);
    pulse(0, 5, 20, 20'd20);
    #1 enable = 1'b0;
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
`else
    // Single 37-cycle echo on ch0, then gap timing to ch1.
    wait_trig(0, f);
    pulse(0, 10, 37, 20'd37);
    wait_trig(1, f);
    chk("gap_to_trig1", 64'(rise_cyc - last_valid_cyc), 64'd9);
    // ch1 silent -> timeout; meanwhile hold a stale echo on ch2.
    e = '{ch: 1, val: ALL1, tmo: 1'b1, due: f + TMO};
    sb.push_back(e);
    echo[2] = 1'b1;
    wait_trig(2, f);
    repeat (20) @(posedge clk);
    #1 echo[2] = 1'b0;
    pulse(2, 10, 12, 20'd12);
    // Round-robin wrap with short echoes.
    wait_trig(0, f);
    pulse(0, 3, 5, 20'd5);
    wait_trig(1, f);
    pulse(1, 3, 6, 20'd6);
    wait_trig(2, f);
    pulse(2, 3, 7, 20'd7);
    // Drop enable mid-measurement on ch0: result still published, then idle.
    wait_trig(0, f);
    repeat (5) @(posedge clk);
    #1 echo[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1 enable = 1'b0;
    repeat (5) @(posedge clk);
    #1 echo[0] = 1'b0;
    e = '{ch: 0, val: 20'd9, tmo: 1'b0, due: cyc + LAT};
    sb.push_back(e);
    repeat (30) @(negedge clk);
    chk("disable_busy", 64'(busy), 64'd0);
    chk("disable_trig", 64'(trig), 64'd0);
    chk("disable_drained", 64'(sb.size()), 64'd0);
    chk("hold_range0", 64'(rng[0 +: CW]), 64'd9);
    chk("hold_range1", 64'(rng[CW +: CW]), 64'd6);
    chk("hold_range2", 64'(rng[2*CW +: CW]), 64'd7);
    // Resume at the channel after the one that was interrupted.
    @(posedge clk);
    #1 enable = 1'b1;
    wait_trig(1, f);
    pulse(1, 2, 20, 20'd20);
    // Reset in the middle of a measurement: nothing may be published.
    wait_trig(2, f);
    repeat (6) @(posedge clk);
    #1 echo[2] = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #2;
    chk("midreset_trig", 64'(trig), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_range", 64'(rng), 64'd0);
    chk("midreset_valid", 64'(rv), 64'd0);
    enable = 1'b0;
    echo = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_reset_busy", 64'(busy), 64'd0);
    chk("post_reset_drained", 64'(sb.size()), 64'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
